prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 65535: idle cycles allowed between accepted bytes inside a frame.
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port rx_data  input  8  incoming byte from the serial receiver.
REQ-006 The block SHALL have port rx_valid  input  1  rx_data valid.
REQ-007 The block SHALL have port rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid and rx_ready are both high on a clk edge.
REQ-008 The block SHALL have port wr_enable  output  1  RAM write strobe, one cycle per data byte.
REQ-009 The block SHALL have port addr_bus  output  8  RAM write address.
REQ-010 The block SHALL have port wdata  output  8  RAM write data.
REQ-011 The block SHALL have port cpu_run  output  1  CPU enable; low holds the CPU stopped while RAM is being loaded.
REQ-012 The block SHALL have port load_err  output  1  last frame failed (checksum or timeout).
REQ-013 The block SHALL have port busy  output  1  frame in progress (any state other than IDLE).

Function
REQ-014 Frame format SHALL be: SYNC_BYTE, start address A, length L (0 means 256), L data bytes, then checksum byte when configured.
REQ-015 States SHALL be IDLE, ADDR, LEN, DATA, CSUM; all outputs are registered.
REQ-016 rx_ready SHALL be high in every state; bytes are never back-pressured, and back-to-back transfers are accepted every cycle.
REQ-017 In IDLE, an accepted byte equal to SYNC_BYTE SHALL move the block to ADDR, clear cpu_run and load_err, and clear the running checksum; other bytes are discarded with no effect.
REQ-018 ADDR SHALL latch A into the write pointer and add it to the checksum; LEN SHALL latch L into the byte counter, add it to the checksum, and move the block to DATA.
REQ-019 Each byte accepted in DATA SHALL produce, on the next cycle, wr_enable=1, addr_bus=pointer and wdata=byte for exactly one cycle; the pointer then increments mod 256 (FF wraps to 00), the byte is added to the checksum mod 256, and the counter decrements.
REQ-020 After the L-th data byte, the block SHALL go to CSUM if the checksum is enabled, otherwise to IDLE with cpu_run set to 1 one cycle after the final wr_enable pulse.
REQ-021 In CSUM, if the accepted byte equals the 8-bit sum of A, L and all data bytes, the block SHALL go to IDLE with cpu_run=1; otherwise it SHALL go to IDLE with load_err=1 and cpu_run=0.
REQ-022 While busy, TIMEOUT_CYCLES consecutive cycles without an accepted byte SHALL return the block to IDLE with load_err=1 and cpu_run=0; bytes already written stay in RAM.
REQ-023 A SYNC_BYTE value received inside a frame SHALL be treated as ordinary data, not as a restart.
REQ-024 wr_enable SHALL be 0 in every cycle other than the single write cycle of REQ-019.

Reset
REQ-025 While rst is high, the block SHALL be in state IDLE with cpu_run=0, load_err=0, busy=0, wr_enable=0, addr_bus=0, wdata=0, the timeout counter cleared, and any partial frame abandoned.
REQ-026 rx_ready SHALL be 0 while rst is asserted.

Configuration
REQ-027 Macro PROG_LOADER_CHECKSUM_EN defined: the CSUM state and trailing checksum byte SHALL exist per REQ-021.
REQ-028 Macro PROG_LOADER_CHECKSUM_EN undefined: there SHALL be no CSUM state or checksum logic; frames end after the last data byte, and load_err is set only by timeout.

Verification
REQ-029 Bench SHALL cover, with checksum enabled: bytes A5,10,03,01,02,03,19 -> writes 10<=01, 11<=02, 12<=03; cpu_run=1; load_err=0.
REQ-030 Bench SHALL cover: same frame with checksum byte 18 -> three writes still occur, load_err=1, cpu_run=0.
REQ-031 Bench SHALL cover: A5,FE,03,AA,BB,CC,<sum> -> writes at FE, FF, 00 (wrap-around); cpu_run=1.
REQ-032 Bench SHALL cover: bytes 00,37 in IDLE -> no writes, busy=0; then A5,20,00 followed by 256 data bytes of value i -> 256 writes covering 20..1F.
REQ-033 Bench SHALL cover, with TIMEOUT_CYCLES=16: A5,40 then 16 idle cycles -> busy=0, load_err=1; a following valid frame -> load_err=0, cpu_run=1.
REQ-034 Bench SHALL cover: rst asserted mid-DATA (after 2 of 4 bytes) -> wr_enable, cpu_run and busy go 0 immediately; the remaining bytes without a new A5 produce no writes.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream and writes its payload into RAM
// while holding the CPU stopped.
// Frame: SYNC_BYTE, start address, length (0 = 256), data bytes, and
// optionally a trailing checksum byte.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN. When it is defined, the
// CSUM state and the 8-bit additive checksum check are built in. When it is
// undefined, a frame ends after its last data byte.
module prog_loader #(
    parameter int          TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       wr_enable,
    output logic [7:0] addr_bus,
    output logic [7:0] wdata,
    output logic       cpu_run,
    output logic       load_err,
    output logic       busy
);

    // Idle counter width: it only needs to count up to TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3
    } state_t;
`endif

    state_t        state_r;
    logic [7:0]    ptr_r;        // next RAM write address
    logic [8:0]    cnt_r;        // data bytes still expected (1..256)
    logic [CW-1:0] idle_cnt_r;   // consecutive busy cycles with no accepted byte
    logic          done_pend_r;  // frame finished; release the CPU on the next cycle
    logic          accept_s;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]    sum_r;        // running mod-256 sum of address, length and data

    // Adds one byte into the running 8-bit checksum.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction
`endif

    // A byte transfers whenever the sender offers one and we are out of reset.
    assign accept_s = rx_valid & rx_ready;

    // Frame FSM, RAM write strobe, CPU release and timeout supervision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            rx_ready    <= 1'b0;
            wr_enable   <= 1'b0;
            addr_bus    <= 8'd0;
            wdata       <= 8'd0;
            cpu_run     <= 1'b0;
            load_err    <= 1'b0;
            busy        <= 1'b0;
            ptr_r       <= 8'd0;
            cnt_r       <= 9'd0;
            idle_cnt_r  <= {CW{1'b0}};
            done_pend_r <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_r       <= 8'd0;
`endif
        end else begin
            rx_ready  <= 1'b1;
            wr_enable <= 1'b0;

            // The write pulse of the last byte has gone out; now let the CPU run.
            if (done_pend_r) begin
                cpu_run     <= 1'b1;
                done_pend_r <= 1'b0;
            end else begin
                done_pend_r <= 1'b0;
            end

            if (state_r == IDLE) begin
                idle_cnt_r <= {CW{1'b0}};
                // A new frame overrides any CPU release still pending.
                if (accept_s && (rx_data == SYNC_BYTE)) begin
                    state_r     <= ADDR;
                    busy        <= 1'b1;
                    cpu_run     <= 1'b0;
                    load_err    <= 1'b0;
                    done_pend_r <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_r       <= 8'd0;
`endif
                end else begin
                    state_r <= IDLE;
                end
            end else if (accept_s) begin
                idle_cnt_r <= {CW{1'b0}};
                case (state_r)
                    ADDR: begin
                        ptr_r   <= rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_r   <= csum_add(sum_r, rx_data);
`endif
                        state_r <= LEN;
                    end
                    LEN: begin
                        cnt_r   <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_r   <= csum_add(sum_r, rx_data);
`endif
                        state_r <= DATA;
                    end
                    DATA: begin
                        wr_enable <= 1'b1;
                        addr_bus  <= ptr_r;
                        wdata     <= rx_data;
                        ptr_r     <= ptr_r + 8'd1;
                        cnt_r     <= cnt_r - 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_r     <= csum_add(sum_r, rx_data);
`endif
                        if (cnt_r == 9'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_r     <= CSUM;
`else
                            state_r     <= IDLE;
                            busy        <= 1'b0;
                            done_pend_r <= 1'b1;
`endif
                        end else begin
                            state_r <= DATA;
                        end
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    CSUM: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        if (rx_data == sum_r) begin
                            cpu_run  <= 1'b1;
                            load_err <= 1'b0;
                        end else begin
                            cpu_run  <= 1'b0;
                            load_err <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end else if (idle_cnt_r == TO_LAST) begin
                // The sender went quiet mid-frame: abandon it and flag the error.
                state_r     <= IDLE;
                busy        <= 1'b0;
                load_err    <= 1'b1;
                cpu_run     <= 1'b0;
                done_pend_r <= 1'b0;
                idle_cnt_r  <= {CW{1'b0}};
            end else begin
                idle_cnt_r <= idle_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a table of byte vectors with expected
// outputs, followed by hand-written sequences for the long frame, the timeout
// and the reset that arrives mid-frame.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       wr_enable;
    logic [7:0] addr_bus;
    logic [7:0] wdata;
    logic       cpu_run;
    logic       load_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    prog_loader #(.TIMEOUT_CYCLES(16), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .wr_enable (wr_enable),
        .addr_bus  (addr_bus),
        .wdata     (wdata),
        .cpu_run   (cpu_run),
        .load_err  (load_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       bsy;
        logic       cpu;
        logic       err;
    } vec_t;

    vec_t vecs[32];
    int   nv = 0;

    task automatic add(input logic v, input logic [7:0] d, input logic w,
                       input logic [7:0] a, input logic [7:0] wd,
                       input logic b, input logic c, input logic e);
        vecs[nv].valid = v;
        vecs[nv].data  = d;
        vecs[nv].wr    = w;
        vecs[nv].addr  = a;
        vecs[nv].wd    = wd;
        vecs[nv].bsy   = b;
        vecs[nv].cpu   = c;
        vecs[nv].err   = e;
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Offer one byte (or an idle cycle) across one rising edge, then settle.
    task automatic cycle(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] kb;
        logic [3:0] got4;
        logic [3:0] exp4;

        // Frame 1: good checksum 19
        add(1'b1, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h10, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h03, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h01, 1'b1, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h02, 1'b1, 8'h11, 8'h02, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h03, 1'b1, 8'h12, 8'h03, CSUM_ON, 1'b0, 1'b0);
        add(1'b1, 8'h19, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        // Frame 2: same frame, bad checksum 18
        add(1'b1, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h10, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h03, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h01, 1'b1, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h02, 1'b1, 8'h11, 8'h02, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h03, 1'b1, 8'h12, 8'h03, CSUM_ON, 1'b0, 1'b0);
        add(1'b1, 8'h18, 1'b0, 8'h00, 8'h00, 1'b0, !CSUM_ON, CSUM_ON);
        // Frame 3: address wrap FE, FF, 00; sum FE+03+AA+BB+CC = 32; one idle gap
        add(1'b1, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'hFE, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'h77, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'h03, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'hAA, 1'b1, 8'hFE, 8'hAA, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'hBB, 1'b1, 8'hFF, 8'hBB, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'hCC, 1'b1, 8'h00, 8'hCC, CSUM_ON, 1'b0, 1'b0);
        add(1'b1, 8'h32, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        // Non-sync bytes in IDLE are ignored
        add(1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'h37, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset state, including rx_ready held low
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {13'd0, rx_ready, wr_enable, busy, cpu_run, load_err, addr_bus, wdata}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rx_ready_after_reset", {31'd0, rx_ready}, 32'd1);

        // Table-driven frames
        for (int i = 0; i < nv; i++) begin
            cycle(vecs[i].valid, vecs[i].data);
            got4 = {wr_enable, busy, cpu_run, load_err};
            exp4 = {vecs[i].wr, vecs[i].bsy, vecs[i].cpu, vecs[i].err};
            checks++;
            if (got4 !== exp4 || (vecs[i].wr && ({addr_bus, wdata} !== {vecs[i].addr, vecs[i].wd}))) begin
                errors++;
                $display("FAIL vec%0d got wr/busy/cpu/err=%b addr=%h wdata=%h expected %b addr=%h wdata=%h",
                         i, got4, addr_bus, wdata, exp4, vecs[i].addr, vecs[i].wd);
            end
        end

        // 256-byte frame at 20 (length 0); includes A5 as plain data; sum = 20+00+80 = A0
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h20);
        cycle(1'b1, 8'h00);
        for (int k = 0; k < 256; k++) begin
            kb = 8'(k);
            cycle(1'b1, kb);
            chk($sformatf("len256_write%0d", k), {15'd0, wr_enable, addr_bus, wdata},
                {15'd0, 1'b1, 8'(8'h20 + kb), kb});
        end
        cycle(1'b1, 8'hA0);
        chk("len256_done", {28'd0, wr_enable, busy, cpu_run, load_err}, {28'd0, 4'b0010});

        // Timeout: A5,40 then silence; still busy after 15 idle cycles, abandoned after 16
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h40);
        repeat (15) cycle(1'b0, 8'h00);
        chk("timeout_15_still_busy", {31'd0, busy}, 32'd1);
        cycle(1'b0, 8'h00);
        chk("timeout_16", {29'd0, busy, cpu_run, load_err}, {29'd0, 3'b001});
        cycle(1'b1, 8'hA5);
        chk("timeout_err_cleared", {30'd0, busy, load_err}, {30'd0, 2'b10});
        cycle(1'b1, 8'h01);
        cycle(1'b1, 8'h01);
        cycle(1'b1, 8'h77);
        chk("after_timeout_write", {15'd0, wr_enable, addr_bus, wdata}, {15'd0, 1'b1, 8'h01, 8'h77});
        cycle(1'b1, 8'h79);
        chk("after_timeout_done", {29'd0, busy, cpu_run, load_err}, {29'd0, 3'b010});

        // Reset mid-DATA after 2 of 4 bytes
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h50);
        cycle(1'b1, 8'h04);
        cycle(1'b1, 8'h11);
        cycle(1'b1, 8'h22);
        chk("pre_reset_write", {15'd0, wr_enable, addr_bus, wdata}, {15'd0, 1'b1, 8'h51, 8'h22});
        #2;
        rst = 1'b1;
        #1;
        chk("reset_mid_data", {28'd0, wr_enable, cpu_run, busy, rx_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cycle(1'b1, 8'(8'h33 + j));
            chk($sformatf("post_reset_no_write%0d", j), {30'd0, wr_enable, busy}, 32'd0);
        end
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
